// File: rtl/core_inst_sequencer_pkg.sv
// Shared constants, state encoding and instruction field layout for the
// weight-stationary instruction sequencer.
package core_inst_sequencer_pkg;

    localparam int unsigned COL        = 8;
    localparam int unsigned ROW        = 8;
    localparam int unsigned LEN_NIJ    = 36;
    localparam int unsigned LEN_KIJ    = 9;
    localparam int unsigned LEN_ONIJ   = 16;
    localparam int unsigned ADDR_W     = 11;
    localparam int unsigned RST_CYCLES = 4;
    localparam int unsigned CNT_W      = 9;
    localparam int unsigned INST_W     = 35;

    localparam logic [ADDR_W-1:0] W_BASE = 11'h400;

    localparam int unsigned INST_MODE     = 34;
    localparam int unsigned INST_ACC      = 33;
    localparam int unsigned INST_CEN_PMEM = 32;
    localparam int unsigned INST_WEN_PMEM = 31;
    localparam int unsigned A_PMEM_LSB    = 20;
    localparam int unsigned INST_CEN_XMEM = 19;
    localparam int unsigned INST_WEN_XMEM = 18;
    localparam int unsigned A_XMEM_LSB    = 7;
    localparam int unsigned INST_OFIFO_RD = 6;
    localparam int unsigned INST_IFIFO_WR = 5;
    localparam int unsigned INST_IFIFO_RD = 4;
    localparam int unsigned INST_L0_RD    = 3;
    localparam int unsigned INST_L0_WR    = 2;
    localparam int unsigned INST_EXECUTE  = 1;
    localparam int unsigned INST_LOAD     = 0;

    // Both memories deselected and write-disabled, every strobe low.
    localparam logic [INST_W-1:0] IDLE_INST =
        (INST_W'(1) << INST_CEN_PMEM) | (INST_W'(1) << INST_WEN_PMEM) |
        (INST_W'(1) << INST_CEN_XMEM) | (INST_W'(1) << INST_WEN_XMEM);

    typedef enum logic [3:0] {
        ST_IDLE, ST_CRST, ST_WL0, ST_WLOAD, ST_AL0,
        ST_EXEC, ST_OFRD, ST_ORST, ST_ACC, ST_DONE
    } state_e;

    typedef struct packed {
        logic              mode;
        logic              acc;
        logic              cen_pmem;
        logic              wen_pmem;
        logic [ADDR_W-1:0] a_pmem;
        logic              cen_xmem;
        logic              wen_xmem;
        logic [ADDR_W-1:0] a_xmem;
        logic              ofifo_rd;
        logic              ififo_wr;
        logic              ififo_rd;
        logic              l0_rd;
        logic              l0_wr;
        logic              execute;
        logic              load;
    } inst_fields_t;

    // Number of cycles spent in a state; weight phases double in 2-bit mode.
    function automatic logic [CNT_W-1:0] state_len(state_e st, logic m);
        int unsigned nw;
        int unsigned len;
        nw = m ? 2 * COL : COL;
        case (st)
            ST_CRST:  len = RST_CYCLES;
            ST_WL0:   len = nw;
            ST_WLOAD: len = nw + ROW + 2;
            ST_AL0:   len = LEN_NIJ;
            ST_EXEC:  len = LEN_NIJ + ROW + COL;
            ST_OFRD:  len = LEN_NIJ;
            ST_ACC:   len = LEN_KIJ + 1;
            default:  len = 1;
        endcase
        return CNT_W'(len);
    endfunction

endpackage

// File: rtl/core_inst_sequencer_if.sv
// Control and instruction bus between the sequencer and the core/CSR side.
interface core_inst_sequencer_if;
    import core_inst_sequencer_pkg::*;

    logic              start;
    logic              mode_i;
    logic [ADDR_W-1:0] acc_addr;
    logic [3:0]        acc_onij;
    logic [3:0]        acc_kij;
    logic [INST_W-1:0] inst;
    logic              core_reset;
    logic              busy;
    logic              done;
    logic [3:0]        kij_idx;

    modport master (
        input  start, mode_i, acc_addr,
        output acc_onij, acc_kij, inst, core_reset, busy, done, kij_idx
    );

    modport slave (
        output start, mode_i, acc_addr,
        input  acc_onij, acc_kij, inst, core_reset, busy, done, kij_idx
    );
endinterface

// File: rtl/core_inst_sequencer_inst_encode.sv
// Packs named instruction fields into the 35-bit core instruction word.
module core_inst_sequencer_inst_encode
    import core_inst_sequencer_pkg::*;
(
    input  inst_fields_t      fields,
    output logic [INST_W-1:0] inst_c
);
    always_comb begin
        inst_c                            = '0;
        inst_c[INST_MODE]                 = fields.mode;
        inst_c[INST_ACC]                  = fields.acc;
        inst_c[INST_CEN_PMEM]             = fields.cen_pmem;
        inst_c[INST_WEN_PMEM]             = fields.wen_pmem;
        inst_c[A_PMEM_LSB +: ADDR_W]      = fields.a_pmem;
        inst_c[INST_CEN_XMEM]             = fields.cen_xmem;
        inst_c[INST_WEN_XMEM]             = fields.wen_xmem;
        inst_c[A_XMEM_LSB +: ADDR_W]      = fields.a_xmem;
        inst_c[INST_OFIFO_RD]             = fields.ofifo_rd;
        inst_c[INST_IFIFO_WR]             = fields.ififo_wr;
        inst_c[INST_IFIFO_RD]             = fields.ififo_rd;
        inst_c[INST_L0_RD]                = fields.l0_rd;
        inst_c[INST_L0_WR]                = fields.l0_wr;
        inst_c[INST_EXECUTE]              = fields.execute;
        inst_c[INST_LOAD]                 = fields.load;
    end
endmodule

// File: rtl/core_inst_sequencer.sv
// Weight-stationary tile sequencer: per-kij load/stream/execute/dump, then
// per-onij PMEM accumulation; all outputs are registered decodes of the FSM.
module core_inst_sequencer
    import core_inst_sequencer_pkg::*;
(
    input logic                   clk,
    input logic                   reset,
    core_inst_sequencer_if.master bus
);
    state_e            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt, idx, idx_nxt;
    logic [3:0]        kij, kij_nxt, onij, onij_nxt;
    logic [ADDR_W-1:0] pmem_ptr, pmem_ptr_nxt;
    logic              run_mode, run_mode_nxt;
    inst_fields_t      fields;
    logic [INST_W-1:0] inst_c;
    logic              core_reset_d, busy_d, done_d;
    logic [3:0]        acc_onij_d, acc_kij_d;

    // Position within the current (and next) state, counting up from 0.
    assign idx     = state_len(state, run_mode) - CNT_W'(1) - cnt;
    assign idx_nxt = state_len(state_nxt, run_mode_nxt) - CNT_W'(1) - cnt_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            kij      <= '0;
            onij     <= '0;
            pmem_ptr <= '0;
            run_mode <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            kij      <= kij_nxt;
            onij     <= onij_nxt;
            pmem_ptr <= pmem_ptr_nxt;
            run_mode <= run_mode_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        kij_nxt      = kij;
        onij_nxt     = onij;
        pmem_ptr_nxt = pmem_ptr;
        run_mode_nxt = run_mode;
        if (state != ST_IDLE && cnt != '0) cnt_nxt = cnt - CNT_W'(1);
        case (state)
            ST_IDLE: if (bus.start) begin
                state_nxt    = ST_CRST;
                run_mode_nxt = bus.mode_i;
                kij_nxt      = '0;
                onij_nxt     = '0;
                pmem_ptr_nxt = '0;
            end
            ST_CRST:  if (cnt == '0) state_nxt = ST_WL0;
            ST_WL0:   if (cnt == '0) state_nxt = ST_WLOAD;
            ST_WLOAD: if (cnt == '0) state_nxt = ST_AL0;
            ST_AL0:   if (cnt == '0) state_nxt = ST_EXEC;
            ST_EXEC:  if (cnt == '0) state_nxt = ST_OFRD;
            ST_OFRD: begin
                pmem_ptr_nxt = pmem_ptr + ADDR_W'(1);
                if (cnt == '0) begin
                    if (kij < 4'(LEN_KIJ - 1)) begin
                        kij_nxt   = kij + 4'd1;
                        state_nxt = ST_CRST;
                    end else begin
                        onij_nxt  = '0;
                        state_nxt = ST_ORST;
                    end
                end
            end
            ST_ORST: if (cnt == '0) state_nxt = ST_ACC;
            ST_ACC: if (cnt == '0) begin
                if (onij < 4'(LEN_ONIJ - 1)) begin
                    onij_nxt  = onij + 4'd1;
                    state_nxt = ST_ORST;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (state_nxt != state) cnt_nxt = state_len(state_nxt, run_mode_nxt) - CNT_W'(1);
    end

    always_comb begin
        fields          = '0;
        fields.cen_pmem = 1'b1;
        fields.wen_pmem = 1'b1;
        fields.cen_xmem = 1'b1;
        fields.wen_xmem = 1'b1;
        fields.mode     = (state != ST_IDLE) ? run_mode : 1'b0;
        core_reset_d    = 1'b0;
        done_d          = 1'b0;
        busy_d          = (state != ST_IDLE);
        // Lookup index leads by one cycle so acc_addr is valid while in ACC.
        acc_onij_d = (state_nxt == ST_ORST || state_nxt == ST_ACC) ? onij_nxt : 4'd0;
        acc_kij_d  = (state_nxt == ST_ACC && idx_nxt < CNT_W'(LEN_KIJ)) ? 4'(idx_nxt) : 4'd0;
        case (state)
            ST_CRST, ST_ORST: core_reset_d = 1'b1;
            ST_WL0: begin
                fields.cen_xmem = 1'b0;
                fields.l0_wr    = 1'b1;
                fields.a_xmem   = W_BASE + ADDR_W'(idx);
            end
            ST_WLOAD: begin
                fields.load  = 1'b1;
                fields.l0_rd = (idx < CNT_W'(run_mode ? 2 * COL : COL));
            end
            ST_AL0: begin
                fields.cen_xmem = 1'b0;
                fields.l0_wr    = 1'b1;
                fields.a_xmem   = ADDR_W'(idx);
            end
            ST_EXEC: begin
                fields.execute = 1'b1;
                fields.l0_rd   = 1'b1;
            end
            ST_OFRD: begin
                fields.ofifo_rd = 1'b1;
                fields.cen_pmem = 1'b0;
                fields.wen_pmem = 1'b0;
                fields.a_pmem   = pmem_ptr;
            end
            ST_ACC: begin
                fields.acc = (idx != '0);
                if (idx < CNT_W'(LEN_KIJ)) begin
                    fields.cen_pmem = 1'b0;
                    fields.a_pmem   = bus.acc_addr;
                end
            end
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    core_inst_sequencer_inst_encode u_encode (
        .fields (fields),
        .inst_c (inst_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.inst       <= IDLE_INST;
            bus.core_reset <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.kij_idx    <= '0;
            bus.acc_onij   <= '0;
            bus.acc_kij    <= '0;
        end else begin
            bus.inst       <= inst_c;
            bus.core_reset <= core_reset_d;
            bus.busy       <= busy_d;
            bus.done       <= done_d;
            bus.kij_idx    <= kij;
            bus.acc_onij   <= acc_onij_d;
            bus.acc_kij    <= acc_kij_d;
        end
    end
endmodule
